branch_target_unit: RTL and testbench
=====================================

Name: branch_target_unit

Overview:
- Parametrised successor to the decode-stage branch-target mux.
- Selects the resolved target for equal/not-equal, register-jump and immediate-jump branches in Decode.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for Fetch-stage prediction.
- Issues a registered, one-cycle redirect and flush request to the PC logic whenever Decode disagrees with the prediction carried down from Fetch.

Parameters:
- WIDTH, 32, datapath/PC width in bits (≥ 28).
- BTB_DEPTH, 16, number of BTB entries; power of two, 2..256.
- IDX_W, $clog2(BTB_DEPTH), index width; derived, never overridden.
- TAG_W, WIDTH-2-IDX_W, tag width; derived.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_f  in  WIDTH  Fetch PC for lookup.
- pred_hit_f  out  1  BTB hit on pc_f (combinational).
- pred_taken_f  out  1  hit and counter ≥ 2.
- pred_target_f  out  WIDTH  stored target (0 when no hit).
- stall_d  in  1  Decode stalled; freezes all updates and redirects.
- pc_d  in  WIDTH  PC of the Decode instruction.
- pc_plus4_d  in  WIDTH  fall-through address.
- pc_branch_d  in  WIDTH  PC-relative target.
- rd1_d  in  WIDTH  forwarded rs value.
- instr_d  in  26  instruction [25:0].
- br_eq_d, br_ne_d, br_reg_d, br_imm_d  in  1 each  branch kind; one-hot or all zero.
- cond_d  in  1  comparator result (rs==rt for eq, rs!=rt for ne).
- pred_taken_d  in  1  prediction piped from Fetch.
- pred_target_d  in  WIDTH  predicted target piped from Fetch.
- redirect_v  out  1  registered redirect strobe.
- redirect_pc  out  WIDTH  registered redirect address.
- flush_fd  out  1  equals redirect_v.

Behaviour:
- Reset: all valid bits 0, counters 2'b01, tags/targets 0, redirect_v 0, redirect_pc 0.
- Lookup (combinational):
  - idx = pc_f[IDX_W+1:2], tag = pc_f[WIDTH-1:IDX_W+2].
  - Hit = valid[idx] && tag match.
- Target select, first match wins:
  - br_eq_d|br_ne_d → pc_branch_d.
  - br_reg_d → rd1_d.
  - br_imm_d → {sign-extend of instr_d to WIDTH}.
  - Otherwise 0.
- actual_taken = (br_eq_d|br_ne_d)&cond_d | br_reg_d | br_imm_d.
- Mispredict when a branch is in Decode and either:
  - actual_taken != pred_taken_d, or
  - both are taken and target != pred_target_d.
- A non-branch with pred_taken_d=1 is also a mispredict (aliasing); redirect to pc_plus4_d and invalidate that entry.
- Redirect:
  - On mispredict with !stall_d, next edge sets redirect_v=1 for exactly one cycle.
  - redirect_pc = actual_taken ? target : pc_plus4_d.
  - Latency: one cycle Decode→redirect.
- BTB update on every resolved branch with !stall_d, at the same edge:
  - Allocate entry: valid=1, tag, target, counter=2'b10 if taken else 2'b01.
  - On an existing hit, saturate the counter up or down and refresh the target.
- br_reg_d branches update the counter, but the target is stored only when taken.
- Same-index update and lookup in the same cycle: lookup sees the old contents (write takes effect after the edge).
- stall_d high: no state change; redirect_v forced 0 next cycle.
- Reset asserted mid-redirect: redirect_v drops immediately (asynchronous).
- Multi-hot kind inputs: priority as above, no error.

Optional Feature:
- BTU_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_branches and perf_mispredicts, which count resolved branches and mispredicts.
  - Both reset to 0, freeze on stall_d, and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg holds:
  - br_kind_e enum (NONE, EQ, NE, REG, IMM).
  - Counter constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3.
  - Function sat_update(cnt, taken).
- One natural sub-module, btb_array: storage plus combinational read port and single write port.

Test Plan:
- Reset, then pc_f=0x0040_0010 → pred_hit_f=0, pred_target_f=0, redirect_v=0.
- BEQ at pc_d=0x0040_0010, cond_d=1, pc_branch_d=0x0040_0040, pred_taken_d=0 → next cycle redirect_v=1 and redirect_pc=0x0040_0040 for one cycle; afterwards lookup of 0x0040_0010 gives hit, taken, target 0x0040_0040.
- Same BEQ resolved not-taken three times → counter reaches 0; redirect_pc=pc_plus4_d on the first not-taken only; pred_taken_f=0 afterwards.
- br_reg_d with rd1_d=0x1234_5678 vs pred_target_d=0x1234_5600, both taken → redirect to 0x1234_5678, stored target updated.
- br_imm_d, instr_d=26'h200_0000 → target 0xFE00_0000 (sign-extended).
- stall_d=1 with mispredict present → no redirect and no BTB change; the redirect fires the cycle after stall_d falls.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch target unit: branch kinds,
// 2-bit predictor counter encodings and the counter update rule.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_EQ,
    BR_NE,
    BR_REG,
    BR_IMM
  } br_kind_e;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  function automatic logic [1:0] sat_update(
    input logic [1:0] cnt,
    input logic       taken
  );
    if (taken)
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    else
      return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: valid/tag/target/counter per entry.
// Ports: clk, rst_n; f_* fetch read; d_* decode read; wr_* write.
module btb_array
  import branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = WIDTH - 2 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] f_idx,
  output logic             f_valid,
  output logic [TAG_W-1:0] f_tag,
  output logic [WIDTH-1:0] f_target,
  output logic [1:0]       f_cnt,
  input  logic [IDX_W-1:0] d_idx,
  output logic             d_valid,
  output logic [TAG_W-1:0] d_tag,
  output logic [WIDTH-1:0] d_target,
  output logic [1:0]       d_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [WIDTH-1:0] wr_target,
  input  logic [1:0]       wr_cnt
);

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [WIDTH-1:0] target_q [DEPTH];
  logic [1:0]       cnt_q    [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      cnt_q[wr_idx]    <= wr_cnt;
    end
  end

  assign f_valid  = valid_q[f_idx];
  assign f_tag    = tag_q[f_idx];
  assign f_target = target_q[f_idx];
  assign f_cnt    = cnt_q[f_idx];

  assign d_valid  = valid_q[d_idx];
  assign d_tag    = tag_q[d_idx];
  assign d_target = target_q[d_idx];
  assign d_cnt    = cnt_q[d_idx];

endmodule

// File: rtl/branch_target_unit.sv
// Decode branch resolution, BTB prediction/update, 1-cycle redirect.
// Ports: fetch lookup (pc_f, pred_*_f), decode inputs (*_d),
// redirect_v/redirect_pc/flush_fd; BTU_PERF_CNT_EN adds perf_* counters.
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BTB_DEPTH = 16,
  localparam int IDX_W = $clog2(BTB_DEPTH),
  localparam int TAG_W = WIDTH - 2 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_f,
  output logic             pred_hit_f,
  output logic             pred_taken_f,
  output logic [WIDTH-1:0] pred_target_f,
  input  logic             stall_d,
  input  logic [WIDTH-1:0] pc_d,
  input  logic [WIDTH-1:0] pc_plus4_d,
  input  logic [WIDTH-1:0] pc_branch_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [25:0]      instr_d,
  input  logic             br_eq_d,
  input  logic             br_ne_d,
  input  logic             br_reg_d,
  input  logic             br_imm_d,
  input  logic             cond_d,
  input  logic             pred_taken_d,
  input  logic [WIDTH-1:0] pred_target_d,
`ifdef BTU_PERF_CNT_EN
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts,
`endif
  output logic             redirect_v,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_fd
);

  logic [IDX_W-1:0] f_idx, d_idx;
  logic [TAG_W-1:0] f_tag_in, d_tag_in;
  logic             f_valid, d_valid;
  logic [TAG_W-1:0] f_tag, d_tag;
  logic [WIDTH-1:0] f_target, d_target;
  logic [1:0]       f_cnt, d_cnt;
  logic             d_hit;

  logic             wr_en, wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [WIDTH-1:0] wr_target;
  logic [1:0]       wr_cnt;

  br_kind_e         kind;
  logic             is_br, taken, mispredict;
  logic [WIDTH-1:0] target;

  logic unused;
  assign unused = ^{pc_f[1:0], pc_d[1:0], f_cnt[0]};

  assign f_idx    = pc_f[IDX_W+1:2];
  assign f_tag_in = pc_f[WIDTH-1:IDX_W+2];
  assign d_idx    = pc_d[IDX_W+1:2];
  assign d_tag_in = pc_d[WIDTH-1:IDX_W+2];

  btb_array #(
    .WIDTH (WIDTH),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_idx     (f_idx),
    .f_valid   (f_valid),
    .f_tag     (f_tag),
    .f_target  (f_target),
    .f_cnt     (f_cnt),
    .d_idx     (d_idx),
    .d_valid   (d_valid),
    .d_tag     (d_tag),
    .d_target  (d_target),
    .d_cnt     (d_cnt),
    .wr_en     (wr_en),
    .wr_idx    (d_idx),
    .wr_valid  (wr_valid),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_cnt    (wr_cnt)
  );

  assign pred_hit_f    = f_valid && (f_tag == f_tag_in);
  assign pred_taken_f  = pred_hit_f && f_cnt[1];
  assign pred_target_f = pred_hit_f ? f_target : '0;

  assign d_hit = d_valid && (d_tag == d_tag_in);

  // Multi-hot kinds resolve by priority, never flagged.
  always_comb begin
    kind = BR_NONE;
    case (1'b1)
      br_eq_d:  kind = BR_EQ;
      br_ne_d:  kind = BR_NE;
      br_reg_d: kind = BR_REG;
      br_imm_d: kind = BR_IMM;
      default:  kind = BR_NONE;
    endcase
  end

  always_comb begin
    target = '0;
    case (kind)
      BR_EQ, BR_NE: target = pc_branch_d;
      BR_REG:       target = rd1_d;
      BR_IMM:       target = {{(WIDTH-26){instr_d[25]}}, instr_d};
      default:      target = '0;
    endcase
  end

  assign is_br = (kind != BR_NONE);
  assign taken = ((br_eq_d | br_ne_d) & cond_d) | br_reg_d | br_imm_d;

  // A non-branch predicted taken is a BTB alias.
  always_comb begin
    mispredict = 1'b0;
    if (is_br)
      mispredict = (taken != pred_taken_d) ||
                   (taken && pred_taken_d &&
                    (target != pred_target_d));
    else
      mispredict = pred_taken_d;
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_tag    = d_tag_in;
    wr_target = d_target;
    wr_cnt    = d_cnt;
    if (!stall_d) begin
      if (is_br) begin
        wr_en = 1'b1;
        if (d_hit) begin
          wr_cnt = sat_update(d_cnt, taken);
          if (kind != BR_REG || taken)
            wr_target = target;
        end else begin
          wr_cnt    = taken ? CNT_WT : CNT_WNT;
          wr_target = (kind != BR_REG || taken) ? target : '0;
        end
      end else if (pred_taken_d && d_hit) begin
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_v  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_v <= mispredict && !stall_d;
      if (mispredict && !stall_d)
        redirect_pc <= taken ? target : pc_plus4_d;
    end
  end

  assign flush_fd = redirect_v;

`ifdef BTU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (!stall_d) begin
      if (is_br)
        perf_branches <= perf_branches + 32'd1;
      if (mispredict)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit.
// Each task drives one scenario and checks inline.
module tb_branch_target_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_hit_f, pred_taken_f;
  logic [31:0] pred_target_f;
  logic        stall_d;
  logic [31:0] pc_d, pc_plus4_d, pc_branch_d, rd1_d;
  logic [25:0] instr_d;
  logic        br_eq_d, br_ne_d, br_reg_d, br_imm_d;
  logic        cond_d, pred_taken_d;
  logic [31:0] pred_target_d;
  logic        redirect_v, flush_fd;
  logic [31:0] redirect_pc;
`ifdef BTU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_target_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_f          (pc_f),
    .pred_hit_f    (pred_hit_f),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .stall_d       (stall_d),
    .pc_d          (pc_d),
    .pc_plus4_d    (pc_plus4_d),
    .pc_branch_d   (pc_branch_d),
    .rd1_d         (rd1_d),
    .instr_d       (instr_d),
    .br_eq_d       (br_eq_d),
    .br_ne_d       (br_ne_d),
    .br_reg_d      (br_reg_d),
    .br_imm_d      (br_imm_d),
    .cond_d        (cond_d),
    .pred_taken_d  (pred_taken_d),
    .pred_target_d (pred_target_d),
`ifdef BTU_PERF_CNT_EN
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts),
`endif
    .redirect_v    (redirect_v),
    .redirect_pc   (redirect_pc),
    .flush_fd      (flush_fd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_d       = 1'b0;
    br_eq_d       = 1'b0;
    br_ne_d       = 1'b0;
    br_reg_d      = 1'b0;
    br_imm_d      = 1'b0;
    cond_d        = 1'b0;
    pred_taken_d  = 1'b0;
    pred_target_d = '0;
    rd1_d         = '0;
    instr_d       = '0;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    pc_d        = pc;
    pc_plus4_d  = pc + 32'd4;
    pc_f        = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_pc(32'h0040_0010);
    pc_branch_d = '0;
    #12;
    checks++;
    if (pred_hit_f !== 1'b0 || pred_target_f !== 32'h0) begin
      errors++;
      $display("FAIL reset_lookup hit=%b tgt=%h want 0/0",
               pred_hit_f, pred_target_f);
    end
    checks++;
    if (redirect_v !== 1'b0 || redirect_pc !== 32'h0 ||
        flush_fd !== 1'b0) begin
      errors++;
      $display("FAIL reset_redirect v=%b pc=%h f=%b want 0",
               redirect_v, redirect_pc, flush_fd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (redirect_v !== 1'b0 || pred_hit_f !== 1'b0) begin
      errors++;
      $display("FAIL post_reset v=%b hit=%b want 0/0",
               redirect_v, pred_hit_f);
    end
  endtask

  task automatic test_alloc();
    set_pc(32'h0040_0010);
    br_eq_d      = 1'b1;
    cond_d       = 1'b1;
    pc_branch_d  = 32'h0040_0040;
    pred_taken_d = 1'b0;
    #1;
    checks++;
    if (pred_hit_f !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_lookup hit=%b want 0", pred_hit_f);
    end
    tick();
    checks++;
    if (redirect_v !== 1'b1 || redirect_pc !== 32'h0040_0040 ||
        flush_fd !== 1'b1) begin
      errors++;
      $display("FAIL alloc_redirect v=%b pc=%h want 1/00400040",
               redirect_v, redirect_pc);
    end
    checks++;
    if (pred_hit_f !== 1'b1 || pred_taken_f !== 1'b1 ||
        pred_target_f !== 32'h0040_0040) begin
      errors++;
      $display("FAIL alloc_lookup hit=%b tk=%b tgt=%h want 1/1/00400040",
               pred_hit_f, pred_taken_f, pred_target_f);
    end
    idle();
    tick();
    checks++;
    if (redirect_v !== 1'b0 || flush_fd !== 1'b0) begin
      errors++;
      $display("FAIL alloc_one_cycle v=%b want 0", redirect_v);
    end
  endtask

  task automatic test_not_taken();
    for (int i = 0; i < 3; i++) begin
      set_pc(32'h0040_0010);
      br_eq_d       = 1'b1;
      cond_d        = 1'b0;
      pc_branch_d   = 32'h0040_0040;
      pred_taken_d  = (i == 0);
      pred_target_d = (i == 0) ? 32'h0040_0040 : 32'h0;
      tick();
      checks++;
      if (redirect_v !== (i == 0) ||
          (i == 0 && redirect_pc !== 32'h0040_0014)) begin
        errors++;
        $display("FAIL not_taken_%0d v=%b pc=%h want %0d/00400014",
                 i, redirect_v, redirect_pc, (i == 0));
      end
      idle();
      tick();
    end
    checks++;
    if (pred_hit_f !== 1'b1 || pred_taken_f !== 1'b0) begin
      errors++;
      $display("FAIL not_taken_sat hit=%b tk=%b want 1/0",
               pred_hit_f, pred_taken_f);
    end
  endtask

  task automatic test_reg();
    set_pc(32'h0040_0020);
    br_reg_d      = 1'b1;
    rd1_d         = 32'h1234_5600;
    pred_taken_d  = 1'b1;
    pred_target_d = 32'h1234_5600;
    tick();
    checks++;
    if (redirect_v !== 1'b0 || pred_target_f !== 32'h1234_5600 ||
        pred_taken_f !== 1'b1) begin
      errors++;
      $display("FAIL reg_match v=%b tgt=%h tk=%b want 0/12345600/1",
               redirect_v, pred_target_f, pred_taken_f);
    end
    rd1_d = 32'h1234_5678;
    tick();
    checks++;
    if (redirect_v !== 1'b1 || redirect_pc !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reg_redirect v=%b pc=%h want 1/12345678",
               redirect_v, redirect_pc);
    end
    checks++;
    if (pred_target_f !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reg_refresh tgt=%h want 12345678", pred_target_f);
    end
    idle();
    tick();
  endtask

  task automatic test_imm();
    set_pc(32'h0040_0030);
    br_imm_d     = 1'b1;
    instr_d      = 26'h200_0000;
    pred_taken_d = 1'b0;
    tick();
    checks++;
    if (redirect_v !== 1'b1 || redirect_pc !== 32'hFE00_0000) begin
      errors++;
      $display("FAIL imm_redirect v=%b pc=%h want 1/fe000000",
               redirect_v, redirect_pc);
    end
    checks++;
    if (pred_target_f !== 32'hFE00_0000) begin
      errors++;
      $display("FAIL imm_store tgt=%h want fe000000", pred_target_f);
    end
    idle();
    tick();
  endtask

  task automatic test_alias();
    set_pc(32'h0040_0010);
    pred_taken_d  = 1'b1;
    pred_target_d = 32'h0040_0040;
    tick();
    checks++;
    if (redirect_v !== 1'b1 || redirect_pc !== 32'h0040_0014) begin
      errors++;
      $display("FAIL alias_redirect v=%b pc=%h want 1/00400014",
               redirect_v, redirect_pc);
    end
    checks++;
    if (pred_hit_f !== 1'b0) begin
      errors++;
      $display("FAIL alias_invalidate hit=%b want 0", pred_hit_f);
    end
    idle();
    tick();
  endtask

  task automatic test_stall();
    set_pc(32'h0040_0050);
    br_ne_d      = 1'b1;
    cond_d       = 1'b1;
    pc_branch_d  = 32'h0040_0100;
    pred_taken_d = 1'b0;
    stall_d      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (redirect_v !== 1'b0 || pred_hit_f !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d v=%b hit=%b want 0/0",
                 i, redirect_v, pred_hit_f);
      end
    end
    stall_d = 1'b0;
    tick();
    checks++;
    if (redirect_v !== 1'b1 || redirect_pc !== 32'h0040_0100 ||
        pred_hit_f !== 1'b1) begin
      errors++;
      $display("FAIL stall_release v=%b pc=%h hit=%b want 1/00400100/1",
               redirect_v, redirect_pc, pred_hit_f);
    end
    idle();
    tick();
    checks++;
    if (redirect_v !== 1'b0) begin
      errors++;
      $display("FAIL stall_one_cycle v=%b want 0", redirect_v);
    end
  endtask

  task automatic test_async_reset();
    set_pc(32'h0040_0060);
    br_eq_d      = 1'b1;
    cond_d       = 1'b1;
    pc_branch_d  = 32'h0040_0200;
    pred_taken_d = 1'b0;
    tick();
    checks++;
    if (redirect_v !== 1'b1) begin
      errors++;
      $display("FAIL async_pre v=%b want 1", redirect_v);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (redirect_v !== 1'b0 || redirect_pc !== 32'h0 ||
        pred_hit_f !== 1'b0) begin
      errors++;
      $display("FAIL async_reset v=%b pc=%h hit=%b want 0/0/0",
               redirect_v, redirect_pc, pred_hit_f);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_not_taken();
    test_reg();
    test_imm();
    test_alias();
    test_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
